// File: rtl/aoi_array_pipe_if.sv
// Valid/ready bus for aoi_array_pipe: operand set in, registered result out.
// The producer/consumer side uses master; the pipeline uses slave.
interface aoi_array_pipe_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    localparam int OW = $clog2(WIDTH + 1);

    logic             in_valid;
    logic             in_ready;
    logic [1:0]       mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] d;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic [OW-1:0]    y_ones;
    logic             y_zero;
    logic [CNT_W-1:0] xfer_cnt;

    modport master (
        output in_valid, mode, a, b, c, d, out_ready,
        input  in_ready, out_valid, y, y_ones, y_zero, xfer_cnt
    );

    modport slave (
        input  in_valid, mode, a, b, c, d, out_ready,
        output in_ready, out_valid, y, y_ones, y_zero, xfer_cnt
    );
endinterface

// File: rtl/aoi_array_pipe.sv
// Two-stage valid/ready pipeline applying AOI/AO/OAI/OA bitwise over WIDTH-bit
// operands, with registered popcount, zero flag and a wrapping transfer counter.
module aoi_array_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input logic             clk,
    input logic             rst,
    aoi_array_pipe_if.slave bus
);
    localparam int OW = $clog2(WIDTH + 1);

    function automatic logic [OW-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [OW-1:0] n;
        n = {OW{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            n = n + OW'(v[i]);
        end
        return n;
    endfunction

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [1:0]       mode_q, mode_d;
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [OW-1:0]    ones_q, ones_d;
    logic             zero_q, zero_d;
    logic [CNT_W-1:0] xfer_q, xfer_d;
    logic             s1_load_s;
    logic             s2_load_s;
    logic             in_ready_s;
    logic [WIDTH-1:0] comb_s;

    // Handshake decode and next-state for both pipeline stages and the counter
    always_comb begin
        s2_load_s  = s1_valid_q && (!s2_valid_q || bus.out_ready);
        in_ready_s = !rst && (!s1_valid_q || s2_load_s);
        s1_load_s  = bus.in_valid && in_ready_s;

        s1_valid_d = s1_valid_q;
        p_d        = p_q;
        q_d        = q_q;
        mode_d     = mode_q;
        s2_valid_d = s2_valid_q;
        y_d        = y_q;
        ones_d     = ones_q;
        zero_d     = zero_q;
        xfer_d     = xfer_q;
        comb_s     = mode_q[1] ? (p_q & q_q) : (p_q | q_q);

        // mode[1] picks the OR-first (OAI/OA) or AND-first (AOI/AO) first level
        if (s1_load_s) begin
            p_d        = bus.mode[1] ? (bus.a | bus.b) : (bus.a & bus.b);
            q_d        = bus.mode[1] ? (bus.c | bus.d) : (bus.c & bus.d);
            mode_d     = bus.mode;
            s1_valid_d = 1'b1;
        end else if (s2_load_s) begin
            s1_valid_d = 1'b0;
        end else begin
            s1_valid_d = s1_valid_q;
        end

        if (s2_load_s) begin
            y_d        = mode_q[0] ? comb_s : ~comb_s;
            ones_d     = popcount(y_d);
            zero_d     = (y_d == {WIDTH{1'b0}});
            s2_valid_d = 1'b1;
        end else if (bus.out_ready) begin
            s2_valid_d = 1'b0;
        end else begin
            s2_valid_d = s2_valid_q;
        end

        if (s2_valid_q && bus.out_ready) begin
            xfer_d = xfer_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            xfer_d = xfer_q;
        end
    end

    // State registers with synchronous reset that discards in-flight data
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            p_q        <= {WIDTH{1'b0}};
            q_q        <= {WIDTH{1'b0}};
            mode_q     <= 2'b00;
            s2_valid_q <= 1'b0;
            y_q        <= {WIDTH{1'b0}};
            ones_q     <= {OW{1'b0}};
            zero_q     <= 1'b0;
            xfer_q     <= {CNT_W{1'b0}};
        end else begin
            s1_valid_q <= s1_valid_d;
            p_q        <= p_d;
            q_q        <= q_d;
            mode_q     <= mode_d;
            s2_valid_q <= s2_valid_d;
            y_q        <= y_d;
            ones_q     <= ones_d;
            zero_q     <= zero_d;
            xfer_q     <= xfer_d;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = s2_valid_q;
    assign bus.y         = y_q;
    assign bus.y_ones    = ones_q;
    assign bus.y_zero    = zero_q;
    assign bus.xfer_cnt  = xfer_q;
endmodule

// File: tb/tb_aoi_array_pipe.sv
// Directed bench for aoi_array_pipe: scoreboard of expected results, cycle model
// of stage occupancy, and a 4-bit transfer counter to exercise wrap-around.
module tb_aoi_array_pipe;
    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    typedef struct packed {
        logic [7:0] y;
        logic [3:0] ones;
        logic       zero;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    exp_t sb[$];
    logic m_s1v;
    logic m_s2v;
    logic [CNT_W-1:0] m_xfer;
    logic last_in_fire;

    aoi_array_pipe_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    aoi_array_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [1:0] m, input logic [7:0] a, b, c, d);
        exp_t e;
        logic [7:0] r;
        case (m)
            2'b00:   r = ~((a & b) | (c & d));
            2'b01:   r = (a & b) | (c & d);
            2'b10:   r = ~((a | b) & (c | d));
            default: r = (a | b) & (c | d);
        endcase
        e.y    = r;
        e.ones = 4'($countones(r));
        e.zero = (r == 8'h00);
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: compare at negedge against the model, then advance the model
    task automatic tick();
        logic s2l, exp_ir, in_fire, out_fire;
        @(negedge clk);
        s2l    = m_s1v && (!m_s2v || bus.out_ready);
        exp_ir = !rst && (!m_s1v || s2l);
        check("in_ready", 32'(bus.in_ready), 32'(exp_ir));
        check("out_valid", 32'(bus.out_valid), 32'(m_s2v));
        check("xfer_cnt", 32'(bus.xfer_cnt), 32'(m_xfer));
        if (m_s2v) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 32'(sb.size()), 32'd1);
            end else begin
                check("y", 32'(bus.y), 32'(sb[0].y));
                check("y_ones", 32'(bus.y_ones), 32'(sb[0].ones));
                check("y_zero", 32'(bus.y_zero), 32'(sb[0].zero));
            end
        end
        in_fire  = bus.in_valid && exp_ir;
        out_fire = m_s2v && bus.out_ready && !rst;
        if (in_fire) sb.push_back(model(bus.mode, bus.a, bus.b, bus.c, bus.d));
        if (out_fire && sb.size() > 0) void'(sb.pop_front());
        @(posedge clk);
        #1;
        if (rst) begin
            m_s1v  = 1'b0;
            m_s2v  = 1'b0;
            m_xfer = '0;
            sb.delete();
        end else begin
            if (out_fire) m_xfer = m_xfer + 4'd1;
            m_s2v = s2l ? 1'b1 : (bus.out_ready ? 1'b0 : m_s2v);
            m_s1v = in_fire ? 1'b1 : (s2l ? 1'b0 : m_s1v);
        end
        last_in_fire = in_fire;
    endtask

    task automatic drive(input logic [1:0] m, input logic [7:0] a, b, c, d);
        bus.mode     = m;
        bus.a        = a;
        bus.b        = b;
        bus.c        = c;
        bus.d        = d;
        bus.in_valid = 1'b1;
    endtask

    task automatic wait_accept();
        last_in_fire = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (last_in_fire) break;
        end
        check("accept_timeout", 32'(last_in_fire), 32'd1);
    endtask

    task automatic send(input logic [1:0] m, input logic [7:0] a, b, c, d);
        drive(m, a, b, c, d);
        wait_accept();
    endtask

    task automatic drain();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (sb.size() == 0 && !m_s2v && !m_s1v) break;
            tick();
        end
        check("drain_empty", 32'(sb.size()), 32'd0);
        tick();
    endtask

    task automatic check_reset();
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_y", 32'(bus.y), 32'd0);
        check("rst_y_ones", 32'(bus.y_ones), 32'd0);
        check("rst_y_zero", 32'(bus.y_zero), 32'd0);
        check("rst_xfer", 32'(bus.xfer_cnt), 32'd0);
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        m_s1v         = 1'b0;
        m_s2v         = 1'b0;
        m_xfer        = '0;
        last_in_fire  = 1'b0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drive(2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
        bus.in_valid  = 1'b0;
        @(posedge clk);
        #1;
        tick();
        check_reset();
        rst = 1'b0;

        // Single AOI transfer: y=F0, ones=4
        send(2'b00, 8'hFF, 8'h0F, 8'h00, 8'h00);
        drain();
        check("xfer_first", 32'(bus.xfer_cnt), 32'd1);

        // OAI then OA with identical operands
        send(2'b10, 8'h00, 8'h00, 8'hFF, 8'hFF);
        send(2'b11, 8'h00, 8'h00, 8'hFF, 8'hFF);
        drain();

        // Back-to-back across all four modes
        send(2'b00, 8'hAA, 8'h55, 8'hF0, 8'h0F);
        send(2'b01, 8'hAA, 8'h55, 8'hF0, 8'h0F);
        send(2'b10, 8'hAA, 8'h55, 8'hF0, 8'h0F);
        send(2'b11, 8'hAA, 8'h55, 8'hF0, 8'h0F);
        drain();
        check("xfer_after_b2b", 32'(bus.xfer_cnt), 32'd7);

        // Backpressure: third set must wait, outputs hold
        bus.out_ready = 1'b0;
        send(2'b01, 8'h0F, 8'hFF, 8'h30, 8'h30);
        send(2'b11, 8'h01, 8'h02, 8'h04, 8'h08);
        drive(2'b00, 8'hC3, 8'h81, 8'h00, 8'h00);
        for (int i = 0; i < 3; i++) tick();
        check("stall_in_ready", 32'(bus.in_ready), 32'd0);
        bus.out_ready = 1'b1;
        wait_accept();
        drain();

        // Reset with two entries in flight
        bus.out_ready = 1'b0;
        send(2'b01, 8'hFF, 8'hFF, 8'h00, 8'h00);
        send(2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        tick();
        check_reset();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

        // 17 transfers into a 4-bit counter: 15 -> 0 -> 1
        for (int i = 0; i < 17; i++) begin
            send(2'(i), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        end
        drain();
        check("xfer_wrap", 32'(bus.xfer_cnt), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
